operand_read: RTL
=================

Name: operand_read

Overview:
Register-read stage of the Pillar pipeline. It accepts a decoded instruction, reads rs1/rs2 from the 32x32 architectural register file it owns, and presents operands and immediate to execute through a registered valid/ready output. It is the read-side counterpart of the writeback stage. It receives the writeback port (rd, data, strobe), tracks pending destination writes in a scoreboard, and forwards same-cycle writeback data. It stalls on read-after-write hazards.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural register count (index width 5)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
id_valid_i  in  1  instruction on ir_i/pc_i is valid
id_ready_o  out  1  stage accepts instruction this cycle
ir_i  in  32  instruction word
pc_i  in  32  instruction PC
ex_valid_o  out  1  output bundle valid
ex_ready_i  in  1  execute consumes bundle
ir_o  out  32  registered instruction
pc_o  out  32  registered PC
rs1_data_o  out  32  operand A
rs2_data_o  out  32  operand B
imm_o  out  32  immediate
wb_valid_i  in  1  writeback strobe (one write per cycle)
wb_rd_i  in  5  writeback destination
wb_data_i  in  32  writeback data

Behaviour:
- Decode: opcode = ir_i[6:0]; rd = ir_i[11:7]; rs1 = ir_i[19:15]; rs2 = ir_i[24:20].
- R-type (`DECODE_R_TYPE`) uses rs1 and rs2 and writes rd. I-type (`DECODE_I_TYPE`) uses rs1 only and writes rd. Any other opcode uses no sources and writes nothing.
- Immediate: I-type gives sign-extended ir_i[31:20]. All other opcodes give 0.
- Register file: x0 reads 0 always, and writes to x0 are ignored. On wb_valid_i, regs[wb_rd_i] <= wb_data_i at the clock edge.
- Forwarding: if wb_valid_i, wb_rd_i == source index, and the index is nonzero, the operand takes wb_data_i in the same cycle. Otherwise it takes the regs value.
- Scoreboard pending[31:1]:
  - An issued writing instruction with rd != 0 sets pending[rd].
  - wb_valid_i clears pending[wb_rd_i].
  - If the same index is set and cleared in one cycle, set wins (the new producer is outstanding).
- Hazard: an instruction hazards if any used source s != 0 has pending[s]=1, unless it is forwarded this cycle (wb_valid_i && wb_rd_i==s).
- Output register states:
  - EMPTY: ex_valid_o=0.
  - FULL: ex_valid_o=1.
- Output register transitions:
  - free = EMPTY, or (FULL and ex_ready_i).
  - id_ready_o = free && !hazard (combinational; depends on ir_i when id_valid_i).
  - Issue = id_valid_i && id_ready_o. On issue, load ir_o, pc_o, operands and imm; state becomes FULL.
  - FULL && ex_ready_i with no issue: state becomes EMPTY.
  - FULL && !ex_ready_i: outputs hold stable; no new issue.
- Latency: one cycle from issue to ex_valid_o. Throughput is one instruction per cycle when there are no hazards.
- Stall: while hazarded, id_ready_o=0. Issue happens in the cycle the matching writeback arrives, via forwarding.
- Reset (async, any time, including mid-stall):
  - ex_valid_o=0, id_ready_o follows the combinational rule.
  - ir_o, pc_o, rs1_data_o, rs2_data_o, imm_o = 0.
  - All regs 0, all pending 0.
  - The instruction in flight is discarded.
- Writeback to an index that is not pending still updates regs; that is legal.

Test Plan:
- Reset, then issue I-type addi x1,x0,5 (ir=0x00500093) with wb idle -> next cycle ex_valid_o=1, rs1_data_o=0, imm_o=5, pending[1]=1.
- Issue R-type add x3,x1,x2 (ir=0x002081B3) while pending[1]=1 and no wb -> id_ready_o=0. Pulse wb_valid_i with rd=1, data=0x5 -> issues that cycle with rs1_data_o=5 next cycle.
- I-type with ir[31:20]=0xFFF -> imm_o=0xFFFFFFFF. Write x0 via wb data 0x1234, then read x0 -> operand 0.
- Hold ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> all outputs stable and id_ready_o=0. Raise ex_ready_i with a new valid instruction -> back-to-back issue without a bubble.
- Same cycle: issue writes x4 while wb_valid_i clears x4 -> pending[4]=1 afterward. A following reader of x4 stalls until the next wb to x4.
- Assert reset while stalled and FULL -> ex_valid_o=0 immediately (asynchronous) and all pending cleared. After release, a reader of x1 issues without stall with rs1_data_o=0.

Source files
------------

// File: rtl/operand_read.sv
// Register-read stage: owns the 32x32 register file, tracks outstanding writers
// in a scoreboard and hands operands to execute through a one-entry output register.
module operand_read #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [31:0]     ir_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [31:0]     ir_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i
);

  localparam logic [6:0] DECODE_R_TYPE = 7'b0110011;
  localparam logic [6:0] DECODE_I_TYPE = 7'b0010011;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending, pending_next;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic            is_r, is_i, uses_rs1, uses_rs2, writes_rd;
  logic            fwd1, fwd2, hazard, free, issue;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_val;

  assign opcode    = ir_i[6:0];
  assign rd        = ir_i[11:7];
  assign rs1       = ir_i[19:15];
  assign rs2       = ir_i[24:20];
  assign is_r      = (opcode == DECODE_R_TYPE);
  assign is_i      = (opcode == DECODE_I_TYPE);
  assign uses_rs1  = is_r || is_i;
  assign uses_rs2  = is_r;
  assign writes_rd = (is_r || is_i) && (rd != 5'd0);
  assign imm_val   = is_i ? {{(XLEN-12){ir_i[31]}}, ir_i[31:20]} : '0;

  assign fwd1 = wb_valid_i && (wb_rd_i == rs1) && (rs1 != 5'd0);
  assign fwd2 = wb_valid_i && (wb_rd_i == rs2) && (rs2 != 5'd0);

  // A pending source is only a hazard if this cycle's writeback cannot cover it
  assign hazard = id_valid_i &&
                  ((uses_rs1 && rs1 != 5'd0 && pending[rs1] && !fwd1) ||
                   (uses_rs2 && rs2 != 5'd0 && pending[rs2] && !fwd2));

  assign free       = (state == EMPTY) || ex_ready_i;
  assign id_ready_o = free && !hazard;
  assign issue      = id_valid_i && id_ready_o;
  assign ex_valid_o = (state == FULL);

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (uses_rs1 && rs1 != 5'd0) rs1_val = fwd1 ? wb_data_i : regs[rs1];
    if (uses_rs2 && rs2 != 5'd0) rs2_val = fwd2 ? wb_data_i : regs[rs2];
  end

  // Set after clear, so an issuing producer wins over a retiring one on the same index
  always_comb begin
    pending_next = pending;
    if (wb_valid_i) pending_next[wb_rd_i] = 1'b0;
    if (issue && writes_rd) pending_next[rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    state_next = state;
    if (issue) state_next = FULL;
    else if (state == FULL && ex_ready_i) state_next = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      pending <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      if (wb_valid_i && wb_rd_i != 5'd0) regs[wb_rd_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_o       <= '0;
      pc_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
    end else if (issue) begin
      ir_o       <= ir_i;
      pc_o       <= pc_i;
      rs1_data_o <= rs1_val;
      rs2_data_o <= rs2_val;
      imm_o      <= imm_val;
    end
  end

endmodule
